// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between NREQ writeback requesters.
// Optional busy scoreboard (sb_set/sb_addr/busy) is built when SCOREBOARD_EN is defined.
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int DW   = 19,
    parameter int AW   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hold,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
`ifdef SCOREBOARD_EN
    input  logic               sb_set,
    input  logic [AW-1:0]      sb_addr,
    output logic [15:0]        busy,
`endif
    output logic               we,
    output logic [AW-1:0]      wa,
    output logic [DW-1:0]      wd,
    output logic [1:0]         grant_id
);

    logic [AW-1:0] addr_arr [NREQ];
    logic [DW-1:0] data_arr [NREQ];
    logic [1:0]    rr_ptr_reg;
    logic [1:0]    rr_ptr_next;
    logic [1:0]    grant_idx;
    logic          grant_found;
    logic          handshake;
    logic [2:0]    cand;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
        assign addr_arr[gi]  = req_addr[gi*AW +: AW];
        assign data_arr[gi]  = req_data[gi*DW +: DW];
        assign req_ready[gi] = handshake && (grant_idx == 2'(gi));
    end

    // Walk offsets from farthest to nearest so the requester closest to rr_ptr wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = 2'd0;
        cand        = 3'd0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_reg} + 3'(k);
            if (cand >= 3'(NREQ)) begin
                cand = cand - 3'(NREQ);
            end
            if (req_valid[cand[1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[1:0];
            end
        end
    end

    assign handshake   = rst && !hold && grant_found;
    assign rr_ptr_next = (grant_idx == 2'(NREQ - 1)) ? 2'd0 : grant_idx + 2'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we         <= 1'b0;
            wa         <= '0;
            wd         <= '0;
            grant_id   <= 2'd0;
            rr_ptr_reg <= 2'd0;
        end else begin
            // Writes to r0 complete the handshake but never assert we.
            we <= handshake && (addr_arr[grant_idx] != '0);
            if (handshake) begin
                wa         <= addr_arr[grant_idx];
                wd         <= data_arr[grant_idx];
                grant_id   <= grant_idx;
                rr_ptr_reg <= rr_ptr_next;
            end
        end
    end

`ifdef SCOREBOARD_EN
    logic [15:0] busy_next;

    // Clear first so a coincident set on the same register takes priority.
    always_comb begin
        busy_next = busy;
        if (we) begin
            busy_next[wa] = 1'b0;
        end
        if (sb_set && (sb_addr != '0)) begin
            busy_next[sb_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port (WE3/A3/WD3) between NREQ writeback requesters, e.g. ALU, load unit and coprocessor. Uses a valid/ready handshake per requester and a round-robin grant. The granted write is registered and drives the register file one cycle after the handshake. Writes to register 0 are accepted and discarded, keeping r0 at zero.

Parameters:
NREQ, 3, number of writeback requesters (2..4)
DW, 19, data width, matches the register file word
AW, 4, register address width (16 registers)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low
hold  input  1  freezes arbitration; no grants while 1
req_valid  input  NREQ  per-requester write request
req_addr  input  NREQ*AW  packed destination register; slice i belongs to requester i
req_data  input  NREQ*DW  packed write data; slice i belongs to requester i
req_ready  output  NREQ  one-hot grant; handshake completes when valid&ready
we  output  1  to register file WE3
wa  output  AW  to register file A3
wd  output  DW  to register file WD3
grant_id  output  2  index of the requester whose write is on we/wa/wd

Behaviour:
- Reset (rst=0, asynchronous): we=0, wa=0, wd=0, grant_id=0, rr_ptr=0, req_ready=0.
  - While rst=0, req_ready stays 0 regardless of inputs.
  - An accepted write not yet driven onto we is lost; requesters re-issue.
- Arbitration (combinational, per cycle):
  - If hold=0, search req_valid starting at index rr_ptr and moving upward with wrap-around. The first set bit g is granted: req_ready = one-hot(g).
  - If no valid request, or hold=1, req_ready=0.
- rr_ptr update: on a completed handshake rr_ptr <= (g+1) mod NREQ. Otherwise it is unchanged, including during hold.
- Output register, latency 1:
  - After a handshake by g, the next cycle has we = (req_addr[g]!=0), wa=req_addr[g], wd=req_data[g], grant_id=g.
  - With no handshake: we<=0; wa, wd and grant_id hold their previous values.
- At most one write per cycle; sustained throughput is 1 write/cycle.
- Address 0: the handshake completes and rr_ptr advances, but we stays 0. wa/wd still update.
- Requester rule: once req_valid is asserted, req_addr, req_data and req_valid stay stable until req_ready is seen. The bench flags any violation; the design does not check it.
- Same register written by two requesters on consecutive grants: both writes issue in grant order; the last write wins in the register file.
- hold rising while a write is in the output register: that write still issues (we=1) the next cycle. Nothing new is granted.
- Single requester valid continuously: it is granted every cycle.

Optional Feature:
Macro SCOREBOARD_EN.
- With the macro defined, the block adds these ports:
  - sb_set (input, 1)
  - sb_addr (input, AW)
  - busy (output, 16)
- sb_set=1 sets busy[sb_addr] next cycle; sb_addr=0 is ignored.
- busy[wa] clears in the cycle after we=1 for that address.
- Simultaneous set and clear of the same bit: set wins.
- Reset clears busy to 0.
- Without the macro, these ports and the logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset: assert rst=0 mid-stream with valid=3'b111 -> we=0, req_ready=0 immediately; after release, first grant goes to requester 0.
- Round-robin: valid=3'b111 held with addresses 1, 2, 3 and data 0x00011, 0x00022, 0x00033 -> grants 0,1,2,0 on consecutive cycles; we=1 with wa=1,2,3 one cycle after each handshake.
- r0 discard: requester 1 writes addr 0 with data 0x7FFFF -> req_ready[1]=1, next cycle we=0, rr_ptr=2.
- Hold: valid=3'b010 with hold=1 for 4 cycles -> req_ready=0, we=0 throughout; on hold=0 the grant goes to requester 1 on the first cycle.
- Back-to-back same address: requesters 0 and 2 both target addr 5 with 0x00AAA and 0x00BBB -> two consecutive we pulses; a later read of r5 returns 0x00BBB when rr_ptr starts at 0.
- SCOREBOARD_EN: sb_set with addr 7 -> busy[7]=1; a write to r7 sets we=1, then busy[7]=0 the following cycle; sb_set(7) coinciding with the clear cycle leaves busy[7]=1.
